// File: rtl/cell_sort_drain_if.sv
// Sorted-entry output stream of cell_sort_drain: key, metadata and last flag under valid/ready.
interface cell_sort_drain_if #(
  parameter int SORTB = 8,
  parameter int METAB = 32
);
  logic [SORTB-1:0] data_o;
  logic [METAB-1:0] metadata_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;

  modport master (
    output data_o,
    output metadata_o,
    output valid_o,
    output last_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  metadata_o,
    input  valid_o,
    input  last_o,
    output ready_i
  );
endinterface

// File: rtl/cell_sort_drain.sv
// Snapshots the sort array at frame end, clears it, then streams occupied cells in order; first entry 2 cycles after frame_end.
// Output entry holds while ready_i is low; strobes arriving while busy are dropped and flagged in err_o.
module cell_sort_drain #(
  parameter  int SORTB = 8,
  parameter  int METAB = 32,
  parameter  int DEPTH = 16,
  localparam int CNTB  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH*SORTB-1:0] cells_data_i,
  input  logic [DEPTH*METAB-1:0] cells_metadata_i,
  input  logic                   dav_i,
  input  logic                   frame_end_i,
  output logic                   array_clr_o,
  output logic                   busy_o,
  cell_sort_drain_if.master      dout,
  output logic [CNTB-1:0]        count_o,
  output logic                   err_o
);

  localparam int              IDXB = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTB-1:0] FULL = CNTB'(DEPTH);
  localparam logic [CNTB-1:0] ONE  = CNTB'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNTB-1:0]        cnt_q, cnt_d;
  logic [CNTB-1:0]        count_q, count_d;
  logic [IDXB-1:0]        idx_q, idx_d;
  logic                   err_q, err_d;
  logic [DEPTH*SORTB-1:0] key_q, key_d;
  logic [DEPTH*METAB-1:0] meta_q, meta_d;

  logic draining;
  logic is_last;
  logic xfer;

  assign draining = (state_q == S_DRAIN);
  assign is_last  = draining && (CNTB'(idx_q) == (count_q - ONE));
  assign xfer     = draining && dout.ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    idx_d   = idx_q;
    err_d   = err_q;
    key_d   = key_q;
    meta_d  = meta_q;

    // Any strobe outside IDLE is a protocol violation and has no other effect.
    if ((state_q != S_IDLE) && (dav_i || frame_end_i)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dav_i && (cnt_q != FULL)) begin
          cnt_d = cnt_q + ONE;
        end
        if (frame_end_i) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // Inputs still hold the pre-clear cell contents in this cycle.
        key_d   = cells_data_i;
        meta_d  = cells_metadata_i;
        count_d = cnt_q;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = (cnt_q == '0) ? S_IDLE : S_DRAIN;
      end

      S_DRAIN: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (is_last) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Shadow contents are only meaningful after a capture, so they carry no reset.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    meta_q <= meta_d;
  end

  assign array_clr_o     = (state_q == S_CAPTURE);
  assign busy_o          = (state_q != S_IDLE);
  assign count_o         = count_q;
  assign err_o           = err_q;
  assign dout.valid_o    = draining;
  assign dout.last_o     = is_last;
  assign dout.data_o     = draining ? key_q[idx_q*SORTB +: SORTB]  : '0;
  assign dout.metadata_o = draining ? meta_q[idx_q*METAB +: METAB] : '0;

endmodule

// File: doc/cell_sort_drain.md
# cell_sort_drain

Downstream readout stage for the systolic insertion-sort array of `unit_cell` instances. At the end of a sort frame it snapshots every cell's key and metadata in parallel and issues a one-cycle clear to the array, so the array can accept the next frame. It then streams the captured entries out in sorted order over a valid/ready handshake, tagging the final entry with `last_o`. It also counts the frame's inserts so that only occupied cells are emitted.

## Interface
- `SORTB`, 8, key width; matches the array.
- `METAB`, 32, metadata width; matches the array.
- `DEPTH`, 16, number of cells in the array; must be ≥ 2.
- `CNTB`, `$clog2(DEPTH+1)`, derived entry-count width; not overridden.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `cells_data_i`  in  DEPTH*SORTB  all cell keys; cell i occupies bits [i*SORTB +: SORTB]. Cell 0 is the chain head and holds the most extreme key.
- `cells_metadata_i`  in  DEPTH*METAB  all cell metadata, packed the same way.
- `dav_i`  in  1  the array's insert strobe; one insert per cycle in which it is high.
- `frame_end_i`  in  1  single-cycle pulse marking the end of a frame; may coincide with the frame's last `dav_i`.
- `array_clr_o`  out  1  one-cycle clear to the array, OR-ed into the cells' `rst` by the parent.
- `busy_o`  out  1  high from the capture cycle until the final transfer completes.
- `data_o`  out  SORTB  key of the current entry.
- `metadata_o`  out  METAB  metadata of the current entry.
- `valid_o`  out  1  the current entry is valid.
- `ready_i`  in  1  downstream accepts the entry.
- `last_o`  out  1  the current entry is the final entry of the frame.
- `count_o`  out  CNTB  number of entries captured for the frame being drained.
- `err_o`  out  1  sticky protocol error; cleared only by `rst`.

## Operation
- **FSM states:** IDLE, CAPTURE, DRAIN.
- **IDLE:**
  - The insert counter `cnt` increments on each `dav_i` and saturates at DEPTH. Inserts beyond DEPTH displace the worst entry and are not an error.
  - On `frame_end_i`, the `dav_i` of that same cycle is counted. The FSM then moves to CAPTURE and `array_clr_o` is registered high.
- **CAPTURE (exactly one cycle):**
  - Shadow registers load all DEPTH keys and metadata from the inputs. These are pre-clear values, since the array clears at the same edge.
  - `count_o` is set to `cnt`, and `cnt` is reset to 0. The read index `idx` is set to 0.
  - If `cnt` = 0, the FSM returns to IDLE and no entry is emitted. Otherwise it moves to DRAIN.
- **DRAIN:**
  - `valid_o` is high. `data_o` and `metadata_o` present shadow entry `idx`.
  - `last_o` = (`idx` == `count_o`−1).
  - A transfer occurs when `valid_o` && `ready_i`. On a transfer, `idx` increments. A transfer with `last_o` high returns the FSM to IDLE.
  - Entries are emitted in cell order 0..count−1, which is the array's sort order (descending for REV=0, ascending for REV=1). The block is agnostic to REV.
- **Error:** `dav_i` or `frame_end_i` high while `busy_o` is high sets `err_o`. The offending strobe is otherwise ignored: it is not counted and starts no frame.
- **Reset:** `rst` in any state, including mid-drain, forces IDLE. All outputs become 0, and `cnt`, `idx` and `err_o` are cleared. Shadow contents are don't-care.

## Timing
- `frame_end_i` is high in cycle k.
- `array_clr_o` and `busy_o` are high in cycle k+1 (CAPTURE).
- `valid_o` is first high in cycle k+2.
- `array_clr_o` is high for exactly one cycle per frame, including frames with zero inserts.
- Zero-insert frame: `busy_o` is high only in k+1 and the block is IDLE in k+2.
- Drain throughput is one entry per cycle with `ready_i` held high. `count_o` entries finish in cycles k+2 .. k+1+`count_o`, and `busy_o` falls in the cycle after the last transfer.
- While `valid_o` is high and `ready_i` is low, `data_o`, `metadata_o`, `last_o` and `valid_o` hold stable. `valid_o` never drops without a transfer (except on `rst`).
- The earliest next-frame `dav_i` is the first cycle with `busy_o` low.
- All outputs are registered or decoded from registered state. There is no combinational path from `ready_i` to `valid_o`.
- Reset values of all outputs (`array_clr_o`, `busy_o`, `data_o`, `metadata_o`, `valid_o`, `last_o`, `count_o`, `err_o`) are 0.

## Test plan
- **Basic frame:** DEPTH=4, REV=0 array. Insert keys 5, 9, 2 (metadata 0xA, 0xB, 0xC), with `frame_end_i` on the cycle of the insert of 2. Required: `array_clr_o` pulses at k+1; entries out are (9,0xB), (5,0xA), (2,0xC); `last_o` only on key 2; `count_o`=3.
- **Overfill:** DEPTH=4, insert 1..6. Required: `count_o`=4; out 6, 5, 4, 3; `last_o` on 3; `err_o`=0.
- **Backpressure:** during the basic frame, hold `ready_i` low for 3 cycles while key 5 is presented. Required: `data_o`=5 stable throughout; no duplicate or skipped entry; sequence 9, 5, 2.
- **Empty frame:** `frame_end_i` with no inserts. Required: one `array_clr_o` pulse; `busy_o` high for one cycle; `valid_o` never high.
- **Protocol error:** `dav_i` high during DRAIN. Required: `err_o`=1 and stays set; drain output unchanged; the next frame's count excludes the stray insert.
- **Reset mid-drain:** assert `rst` after the first transfer. Required: next cycle `valid_o`, `busy_o`, `count_o` and `err_o` are 0; a following 2-insert frame drains correctly.
